// File: rtl/ir_key_fifo_if.sv
// Bundle of frame input, pop/flush controls and FIFO status for ir_key_fifo.
// Handshake: a frame is taken on a rising edge of iDATA_READY seen while the frame FSM is idle (no backpressure); iRD_EN pops the head whenever oEMPTY is low.
interface ir_key_fifo_if;
    logic        iDATA_READY;
    logic [31:0] iDATA;
    logic        iRD_EN;
    logic        iCLR;
    logic [7:0]  oKEY;
    logic        oEMPTY;
    logic        oFULL;
    logic        oOVERFLOW;
    logic [7:0]  oERR_CNT;
    logic [7:0]  oDROP_CNT;
    logic [1:0]  dbg_state;

    modport master (
        output iDATA_READY, iDATA, iRD_EN, iCLR,
        input  oKEY, oEMPTY, oFULL, oOVERFLOW, oERR_CNT, oDROP_CNT, dbg_state
    );

    modport slave (
        input  iDATA_READY, iDATA, iRD_EN, iCLR,
        output oKEY, oEMPTY, oFULL, oOVERFLOW, oERR_CNT, oDROP_CNT, dbg_state
    );
endinterface

// File: rtl/ir_key_fifo.sv
// IR remote frame checker feeding a first-word-fall-through key FIFO.
// Optional repeat filter for held-down keys: define IR_KEY_REPEAT_FILTER_EN.
module ir_key_fifo #(
    parameter int unsigned DEPTH       = 4,
    parameter logic [15:0] CUSTOMER_ID = 16'h6B86,
    parameter logic [23:0] HOLD_CYCLES = 24'd7500000
) (
    input logic          iCLK,
    input logic          iRST_n,
    ir_key_fifo_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_CHECK = 2'd2,
        S_PUSH  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          rdy_q;
    logic [31:0]   frame_q;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;
    logic [7:0]    err_cnt_q, drop_cnt_q;

    logic          empty, full, pop, rise, frame_ok, filtered;
    logic          push, push_drop, err_inc, drop_inc;
    logic [7:0]    key;

    assign key      = frame_q[23:16];
    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign pop      = bus.iRD_EN && !empty;
    assign rise     = bus.iDATA_READY && !rdy_q;
    assign frame_ok = (frame_q[31:24] == ~frame_q[23:16]) && (frame_q[15:0] == CUSTOMER_ID);

`ifdef IR_KEY_REPEAT_FILTER_EN
    logic [23:0] hold_q;
    logic [7:0]  last_key_q;

    // Window restarts only on an accepted push; filtered repeats do not extend it.
    always_ff @(posedge iCLK) begin
        if (!iRST_n || bus.iCLR) begin
            hold_q     <= '0;
            last_key_q <= '0;
        end else if (push) begin
            hold_q     <= HOLD_CYCLES;
            last_key_q <= key;
        end else if (hold_q != '0) begin
            hold_q <= hold_q - 24'd1;
        end
    end

    assign filtered = (key == last_key_q) && (hold_q != '0);
`else
    assign filtered = 1'b0;
`endif

    always_ff @(posedge iCLK) begin
        if (!iRST_n || bus.iCLR) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_drop = 1'b0;
        err_inc   = 1'b0;
        drop_inc  = 1'b0;
        case (state_q)
            S_IDLE:  if (rise) state_d = S_LATCH;
            S_LATCH: state_d = S_CHECK;
            S_CHECK: begin
                state_d = S_IDLE;
                if (!frame_ok) begin
                    err_inc = 1'b1;
                end else if (filtered) begin
                    drop_inc = 1'b1;
                end else begin
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                state_d = S_IDLE;
                // A pop in the same cycle frees the slot, so a full FIFO still accepts.
                if (!full || pop) begin
                    push = 1'b1;
                end else begin
                    push_drop = 1'b1;
                    drop_inc  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= bus.iDATA_READY;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST_n && !bus.iCLR && push) begin
            mem_q[wr_ptr_q] <= key;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n || bus.iCLR) begin
            frame_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (state_q == S_LATCH) frame_q <= bus.iDATA;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (push_drop) overflow_q <= 1'b1;
            if (err_inc && (err_cnt_q != 8'hFF))   err_cnt_q  <= err_cnt_q + 8'd1;
            if (drop_inc && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign bus.oKEY      = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign bus.oEMPTY    = empty;
    assign bus.oFULL     = full;
    assign bus.oOVERFLOW = overflow_q;
    assign bus.oERR_CNT  = err_cnt_q;
    assign bus.oDROP_CNT = drop_cnt_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_ir_key_fifo.sv
// Self-checking bench for ir_key_fifo: vector table, hand-written corner sequences and a
// randomized run against a transaction-level model (builds with or without IR_KEY_REPEAT_FILTER_EN).
module tb_ir_key_fifo;
    localparam int DEPTH = 4;
`ifdef IR_KEY_REPEAT_FILTER_EN
    localparam int HOLD      = 100;
    localparam bit FILTER_ON = 1'b1;
`else
    localparam int HOLD      = 7500000;
    localparam bit FILTER_ON = 1'b0;
`endif

    logic iCLK   = 1'b0;
    logic iRST_n = 1'b0;

    ir_key_fifo_if bus ();

    ir_key_fifo #(
        .DEPTH      (DEPTH),
        .CUSTOMER_ID(16'h6B86),
        .HOLD_CYCLES(24'(HOLD))
    ) dut (
        .iCLK  (iCLK),
        .iRST_n(iRST_n),
        .bus   (bus)
    );

    always #10 iCLK = ~iCLK;

    initial begin
        #4000000;
        $display("FAIL watchdog: end of test not reached in time");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] data;
        logic        exp_push;
        logic [7:0]  exp_key;
    } vec_t;

    vec_t       vecs [8];
    int         checks = 0;
    int         errors = 0;
    int         now = 0;
    logic [7:0] exp_q [$];
    int         exp_err, exp_drop;
    bit         exp_ovf;
    logic [7:0] last_key;
    int         last_push_rise;

    task automatic tick();
        @(posedge iCLK);
        now++;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] k);
        return {~k, k, 16'h6B86};
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        exp_err        = 0;
        exp_drop       = 0;
        exp_ovf        = 1'b0;
        last_key       = 8'h00;
        last_push_rise = -1000000;
    endfunction

    // Outcome of one frame whose rising edge was sampled at edge n_rise; the check happens
    // two edges later, so a repeat is suppressed while n_rise - last_push_rise <= HOLD + 1.
    function automatic void model_frame(input logic [31:0] d, input int n_rise);
        logic [7:0] k;
        k = d[23:16];
        if ((d[31:24] != ~k) || (d[15:0] != 16'h6B86)) begin
            if (exp_err < 255) exp_err++;
        end else if (FILTER_ON && (k == last_key) && (n_rise - last_push_rise <= HOLD + 1)) begin
            if (exp_drop < 255) exp_drop++;
        end else if (exp_q.size() == DEPTH) begin
            exp_ovf = 1'b1;
            if (exp_drop < 255) exp_drop++;
        end else begin
            exp_q.push_back(k);
            last_key       = k;
            last_push_rise = n_rise;
        end
    endfunction

    task automatic compare_all(input string tag);
        check($sformatf("%s.key", tag),   bus.oKEY, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
        check($sformatf("%s.empty", tag), bus.oEMPTY, exp_q.size() == 0);
        check($sformatf("%s.full", tag),  bus.oFULL, exp_q.size() == DEPTH);
        check($sformatf("%s.ovf", tag),   bus.oOVERFLOW, exp_ovf);
        check($sformatf("%s.err", tag),   bus.oERR_CNT, exp_err);
        check($sformatf("%s.drop", tag),  bus.oDROP_CNT, exp_drop);
    endtask

    task automatic pulse(input logic [31:0] d, input int high, output int n_rise);
        bus.iDATA       = d;
        bus.iDATA_READY = 1'b1;
        tick();
        n_rise = now;
        for (int i = 1; i < high; i++) tick();
        bus.iDATA_READY = 1'b0;
    endtask

    task automatic send_nc(input logic [31:0] d, input int high);
        int n;
        pulse(d, high, n);
        while (now < n + 3) tick();
        model_frame(d, n);
    endtask

    task automatic send(input logic [31:0] d, input int high, input string tag);
        send_nc(d, high);
        compare_all(tag);
    endtask

    task automatic pop(input string tag);
        bus.iRD_EN = 1'b1;
        tick();
        bus.iRD_EN = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        compare_all(tag);
    endtask

    task automatic clear(input string tag);
        bus.iCLR = 1'b1;
        tick();
        bus.iCLR = 1'b0;
        model_reset();
        compare_all(tag);
    endtask

    initial begin
        int n;
        logic [7:0] k;

        vecs[0] = '{32'hF20D6B86, 1'b1, 8'h0D};
        vecs[1] = '{32'hF30D6B86, 1'b0, 8'h00};
        vecs[2] = '{32'hF20D1234, 1'b0, 8'h00};
        vecs[3] = '{32'hFF006B86, 1'b1, 8'h00};
        vecs[4] = '{32'h00FF6B86, 1'b1, 8'hFF};
        vecs[5] = '{32'h5AA56B86, 1'b1, 8'hA5};
        vecs[6] = '{32'h5AA56B87, 1'b0, 8'h00};
        vecs[7] = '{32'hA55A6B86, 1'b1, 8'h5A};

        bus.iDATA_READY = 1'b0;
        bus.iDATA       = '0;
        bus.iRD_EN      = 1'b0;
        bus.iCLR        = 1'b0;
        model_reset();

        // Reset state
        iRST_n = 1'b0;
        tick();
        tick();
        compare_all("reset");
        check("reset.state", bus.dbg_state, 0);
        iRST_n = 1'b1;
        tick();

        // First-frame latency: visible three edges after the sampled rising edge
        bus.iDATA       = 32'hF20D6B86;
        bus.iDATA_READY = 1'b1;
        tick();
        n = now;
        tick();
        tick();
        bus.iDATA_READY = 1'b0;
        check("lat.not_yet_empty", bus.oEMPTY, 1);
        tick();
        model_frame(32'hF20D6B86, n);
        check("lat.key", bus.oKEY, 8'h0D);
        check("lat.empty", bus.oEMPTY, 0);
        compare_all("lat");
        pop("lat.pop_one");
        check("lat.one_entry", bus.oEMPTY, 1);

        // Rejected frames
        send(32'hF30D6B86, 1, "bad_inv");
        check("bad_inv.err1", bus.oERR_CNT, 1);
        send(32'hF20D1234, 2, "bad_cust");
        check("bad_cust.err2", bus.oERR_CNT, 2);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            clear($sformatf("vec%0d.clr", i));
            send(vecs[i].data, 1 + (i % 3), $sformatf("vec%0d", i));
            check($sformatf("vec%0d.tbl_empty", i), bus.oEMPTY, !vecs[i].exp_push);
            check($sformatf("vec%0d.tbl_key", i), bus.oKEY, vecs[i].exp_push ? vecs[i].exp_key : 8'h00);
            check($sformatf("vec%0d.tbl_err", i), bus.oERR_CNT, vecs[i].exp_push ? 0 : 1);
        end

        // Fill, overflow, drain
        clear("fill.clr");
        for (int i = 1; i <= 5; i++) begin
            send(mk(8'(i)), 1, $sformatf("fill%0d", i));
            if (i == 4) check("fill.full_after4", bus.oFULL, 1);
        end
        check("fill.ovf", bus.oOVERFLOW, 1);
        check("fill.drop", bus.oDROP_CNT, 1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain.key%0d", i), bus.oKEY, i);
            pop($sformatf("drain%0d", i));
        end
        check("drain.empty", bus.oEMPTY, 1);
        pop("drain.pop_empty");

        // Push coinciding with a pop while full, across pointer wrap
        clear("wrap.clr");
        for (int i = 1; i <= 4; i++) send(mk(8'(8'h10 * i + i)), 1, $sformatf("wrap.fill%0d", i));
        for (int j = 0; j < 3; j++) begin
            k = 8'h55 + 8'(8'h11 * j);
            pulse(mk(k), 1, n);
            while (now < n + 2) tick();
            bus.iRD_EN = 1'b1;
            tick();
            bus.iRD_EN = 1'b0;
            void'(exp_q.pop_front());
            model_frame(mk(k), n);
            compare_all($sformatf("wrap.co%0d", j));
            check($sformatf("wrap.co%0d.full", j), bus.oFULL, 1);
            check($sformatf("wrap.co%0d.ovf", j), bus.oOVERFLOW, 0);
        end
        for (int i = 0; i < 4; i++) pop($sformatf("wrap.drain%0d", i));

        // Repeat suppression timing
        clear("rep.clr");
        send(mk(8'h05), 1, "rep.first");
        n = now - 3;
        while (now < n + 49) tick();
        send(mk(8'h05), 1, "rep.second");
`ifdef IR_KEY_REPEAT_FILTER_EN
        check("rep.second.drop", bus.oDROP_CNT, 1);
`endif
        while (now < n + 199) tick();
        send(mk(8'h05), 1, "rep.third");
        pop("rep.pop");
        check("rep.second_entry", bus.oEMPTY, 0);

        // Reset in the middle of a frame
        clear("mid.clr");
        send(mk(8'h41), 1, "mid.pre_push");
        send(32'h00000000, 1, "mid.pre_err");
        pulse(mk(8'h42), 1, n);
        tick();
        check("mid.in_check", bus.dbg_state, 2);
        iRST_n = 1'b0;
        tick();
        iRST_n = 1'b1;
        model_reset();
        compare_all("mid.after_rst");
        check("mid.state_idle", bus.dbg_state, 0);
        repeat (4) tick();
        compare_all("mid.no_late_push");
        send(mk(8'h43), 2, "mid.next_frame");

        // Data-ready already high when reset releases
        iRST_n          = 1'b0;
        bus.iDATA       = mk(8'h66);
        bus.iDATA_READY = 1'b1;
        tick();
        model_reset();
        iRST_n = 1'b1;
        tick();
        n = now;
        tick();
        tick();
        bus.iDATA_READY = 1'b0;
        tick();
        model_frame(mk(8'h66), n);
        compare_all("rst_high");

        // Randomized traffic
        clear("rnd.clr");
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 9) < 3) begin
                pop($sformatf("rnd%0d.pop", it));
            end else begin
                repeat ($urandom_range(0, 40)) tick();
                if ($urandom_range(0, 3) == 0) send($urandom, $urandom_range(1, 3), $sformatf("rnd%0d.any", it));
                else send(mk(8'(8'h10 + $urandom_range(0, 3))), $urandom_range(1, 3), $sformatf("rnd%0d.frm", it));
            end
        end

        // Counter saturation
        clear("sat.clr");
        for (int i = 0; i < 260; i++) send_nc(32'h12345678, 1);
        compare_all("sat.err");
        check("sat.err255", bus.oERR_CNT, 255);
        for (int i = 0; i < 264; i++) send_nc(mk(8'($urandom_range(0, 255))), 1);
        compare_all("sat.drop");
        check("sat.drop255", bus.oDROP_CNT, 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ir_key_fifo.md
IR_KEY_FIFO -- requirements
Module: ir_key_fifo

Interface
REQ-001 Parameter: DEPTH, 4, number of FIFO entries; power of two, 2..16.
REQ-002 Parameter: CUSTOMER_ID, 16'h6B86, required value of frame bits [15:0].
REQ-003 Parameter: HOLD_CYCLES, 24'd7500000, repeat-suppress window in iCLK cycles (150 ms at 50 MHz).
REQ-004 iCLK  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-005 iRST_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-006 iDATA_READY  input  1  frame-valid level from the IR receiver; may stay high several cycles.
REQ-007 iDATA  input  32  received frame: [31:24] inverted key, [23:16] key, [15:0] customer code.
REQ-008 iRD_EN  input  1  pop request; consumes the head entry in the cycle it is sampled high.
REQ-009 iCLR  input  1  synchronous flush of FIFO, counters and sticky flags.
REQ-010 oKEY  output  8  head-of-FIFO key code (first-word fall-through); 8'h00 when empty.
REQ-011 oEMPTY  output  1  FIFO holds no entries.
REQ-012 oFULL  output  1  FIFO holds DEPTH entries.
REQ-013 oOVERFLOW  output  1  sticky; a valid frame arrived while full.
REQ-014 oERR_CNT  output  8  saturating count of frames rejected by check (REQ-018).
REQ-015 oDROP_CNT  output  8  saturating count of frames dropped by repeat filter or overflow.

Function
REQ-016 Frame FSM states: S_IDLE, S_LATCH, S_CHECK, S_PUSH; all transitions occur on one iCLK edge.
REQ-017 S_IDLE -> S_LATCH when iDATA_READY is 1 and its registered previous value is 0; S_LATCH samples iDATA into an internal frame register and goes to S_CHECK.
REQ-018 S_CHECK: frame valid iff frame[31:24] == ~frame[23:16] and frame[15:0] == CUSTOMER_ID; invalid -> oERR_CNT+1 (saturate at 255), go to S_IDLE.
REQ-019 S_CHECK valid and not filtered: go to S_PUSH; S_PUSH writes frame[23:16] at the tail if not full, then goes to S_IDLE.
REQ-020 Latency: rising edge of iDATA_READY sampled in cycle N -> oEMPTY low and oKEY valid in cycle N+4 when FIFO was empty.
REQ-021 iDATA_READY rising edges arriving while not in S_IDLE are ignored; each frame is pushed at most once.
REQ-022 Push while full (without simultaneous pop): entry discarded, oOVERFLOW set, oDROP_CNT+1.
REQ-023 Push and iRD_EN in the same cycle while full: pop takes effect, push succeeds, occupancy stays DEPTH, no overflow.
REQ-024 iRD_EN while empty: ignored, pointers unchanged.
REQ-025 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
REQ-026 iCLR: empties FIFO, clears oOVERFLOW, both counters, repeat state, and returns FSM to S_IDLE next cycle; iCLR has priority over push and pop.

Reset
REQ-027 While iRST_n is 0 at a rising iCLK edge: FSM = S_IDLE, pointers/occupancy = 0, oEMPTY = 1, oFULL = 0, oKEY = 8'h00, oOVERFLOW = 0, oERR_CNT = 0, oDROP_CNT = 0, hold counter = 0, last key = 8'h00, edge register = 0.
REQ-028 Reset asserted mid-frame (any FSM state) aborts the frame with no push and no counter update.
REQ-029 Edge register resets to 0, so iDATA_READY already high when reset releases counts as one rising edge.

Configuration
REQ-030 Macro IR_KEY_REPEAT_FILTER_EN defined: in S_CHECK a valid frame whose key equals the last accepted key while the hold counter is nonzero is dropped (oDROP_CNT+1, S_IDLE).
REQ-031 With IR_KEY_REPEAT_FILTER_EN: hold counter loads HOLD_CYCLES on each successful push and decrements by 1 per cycle to 0; different key is never filtered.
REQ-032 Macro undefined: no hold counter or last-key register exists; every valid frame proceeds to S_PUSH.

Verification
REQ-033 Reset, then iDATA = 32'hF20D6B86, iDATA_READY high 3 cycles -> oKEY = 8'h0D, oEMPTY = 0 four cycles after edge; exactly one entry.
REQ-034 iDATA = 32'hF30D6B86 (bad inverse) -> no push, oERR_CNT = 1; iDATA = 32'hF20D1234 -> oERR_CNT = 2.
REQ-035 Five valid frames with distinct keys 01..05, no pops -> oFULL = 1 after fourth, oOVERFLOW = 1, oDROP_CNT = 1; pops return 01,02,03,04 then oEMPTY = 1.
REQ-036 Filter enabled, HOLD_CYCLES = 100: key 05 twice 50 cycles apart -> one entry, oDROP_CNT = 1; third 05 at 200 cycles -> second entry.
REQ-037 FIFO full, pop coincides with S_PUSH -> occupancy stays 4, oOVERFLOW = 0, order preserved across pointer wrap.
REQ-038 iRST_n low during S_CHECK, then released -> oEMPTY = 1, all counters 0, next valid frame accepted normally.
